// File: rtl/flash_program_sequencer_pkg.sv
// Shared definitions for the flash program/erase sequencer: opcode defaults,
// error codes, state encodings and a small saturating-counter helper.
package flash_program_sequencer_pkg;

  // Default flash opcodes and timing limits
  localparam logic [7:0]  DEF_WREN_CMD    = 8'h06;
  localparam logic [7:0]  DEF_RDSR_CMD    = 8'h05;
  localparam logic [7:0]  DEF_PROG_CMD    = 8'h11;
  localparam logic [7:0]  DEF_ERASE_CMD   = 8'hD8;
  localparam int unsigned DEF_POLL_GAP    = 16;
  localparam logic [15:0] DEF_MAX_POLLS   = 16'd50000;
  localparam logic [7:0]  DEF_ACK_TIMEOUT = 8'd255;

  // Sequence result codes reported on err
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_WEL     = 2'b01;
  localparam logic [1:0] ERR_POLL_TO = 2'b10;
  localparam logic [1:0] ERR_ACK_TO  = 2'b11;

  // Top-level sequence states
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WREN    = 3'd1,
    S_WEL_CHK = 3'd2,
    S_OP      = 3'd3,
    S_GAP     = 3'd4,
    S_POLL    = 3'd5,
    S_DONE    = 3'd6
  } seq_state_t;

  // Phases of one memory_controller transaction
  typedef enum logic [1:0] {
    H_IDLE     = 2'd0,
    H_TRIG     = 2'd1,
    H_WAIT_LOW = 2'd2
  } txn_phase_t;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/flash_program_sequencer_mem_txn_handshake.sv
// One memory_controller transaction: latch command fields, raise the trigger,
// wait for busy to rise (or give up after ACK_TIMEOUT trigger cycles), then
// wait for busy to fall.
//
// Handshake: i_start is honoured only in H_IDLE. o_memtrig rises the cycle
// after i_start and stays high until i_mem_busy is sampled high; it is low
// from the following cycle. o_txn_done pulses in the cycle i_mem_busy is
// sampled low with the trigger already low. o_txn_timeout pulses in the last
// trigger-high cycle when busy never rose; the trigger is low the next cycle.
module mem_txn_handshake
  import flash_program_sequencer_pkg::*;
#(
  parameter logic [7:0] ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  input  logic [7:0]  i_cmd,
  input  logic [23:0] i_addr,
  input  logic [47:0] i_val,
  input  logic        i_mem_busy,
  output logic [7:0]  o_memcmd,
  output logic [23:0] o_memaddr,
  output logic [47:0] o_memval,
  output logic        o_memtrig,
  output logic        o_txn_done,
  output logic        o_txn_timeout
);

  txn_phase_t  r_phase;
  txn_phase_t  w_phase_next;
  logic [7:0]  r_ack_cnt;
  logic [7:0]  w_ack_cnt_next;
  logic [7:0]  r_cmd;
  logic [23:0] r_addr;
  logic [47:0] r_val;

  // Phase register, ack counter and command fields held for the transaction
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase   <= H_IDLE;
      r_ack_cnt <= 8'd0;
      r_cmd     <= 8'd0;
      r_addr    <= 24'd0;
      r_val     <= 48'd0;
    end else begin
      r_phase   <= w_phase_next;
      r_ack_cnt <= w_ack_cnt_next;
      if (i_start && (r_phase == H_IDLE)) begin
        r_cmd  <= i_cmd;
        r_addr <= i_addr;
        r_val  <= i_val;
      end
    end
  end

  // Next phase, ack-timeout counting and completion pulses
  always_comb begin
    w_phase_next   = r_phase;
    w_ack_cnt_next = r_ack_cnt;
    o_txn_done     = 1'b0;
    o_txn_timeout  = 1'b0;
    case (r_phase)
      H_IDLE: begin
        if (i_start) begin
          w_phase_next   = H_TRIG;
          w_ack_cnt_next = 8'd0;
        end
      end
      H_TRIG: begin
        if (i_mem_busy) begin
          w_phase_next = H_WAIT_LOW;
        end else if (r_ack_cnt == (ACK_TIMEOUT - 8'd1)) begin
          o_txn_timeout = 1'b1;
          w_phase_next  = H_IDLE;
        end else begin
          w_ack_cnt_next = r_ack_cnt + 8'd1;
        end
      end
      H_WAIT_LOW: begin
        if (!i_mem_busy) begin
          o_txn_done   = 1'b1;
          w_phase_next = H_IDLE;
        end
      end
      default: w_phase_next = H_IDLE;
    endcase
  end

  assign o_memtrig = (r_phase == H_TRIG);
  assign o_memcmd  = r_cmd;
  assign o_memaddr = r_addr;
  assign o_memval  = r_val;

endmodule

// File: rtl/flash_program_sequencer.sv
// Runs a complete flash program or sector-erase sequence on the shared
// memory_controller port: WREN, WEL check, program/erase, then RDSR polling
// spaced by POLL_GAP idle cycles until WIP clears or MAX_POLLS is reached.
//
// Requester handshake: req is sampled only in IDLE; seq_busy is high from the
// cycle after acceptance until done; done is a one-cycle pulse with err valid,
// and err/poll_count hold until the next request is accepted.
module flash_program_sequencer
  import flash_program_sequencer_pkg::*;
#(
  parameter logic [7:0]  WREN_CMD    = DEF_WREN_CMD,
  parameter logic [7:0]  RDSR_CMD    = DEF_RDSR_CMD,
  parameter logic [7:0]  PROG_CMD    = DEF_PROG_CMD,
  parameter logic [7:0]  ERASE_CMD   = DEF_ERASE_CMD,
  parameter int unsigned POLL_GAP    = DEF_POLL_GAP,
  parameter logic [15:0] MAX_POLLS   = DEF_MAX_POLLS,
  parameter logic [7:0]  ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
  input  logic        CLK,
  input  logic        CMD_RST,
  input  logic        req,
  input  logic        req_op,
  input  logic [23:0] req_addr,
  input  logic [47:0] req_data,
  output logic        seq_busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [15:0] poll_count,
  output logic [7:0]  MEMCMD,
  output logic [23:0] MEMADDR,
  output logic [47:0] MEMVAL,
  output logic        MEMTRIG,
  input  logic        MEM_CTRL_busy,
  input  logic [47:0] MEMDATA
);

  seq_state_t  r_state;
  seq_state_t  w_next;
  logic        r_op;
  logic [23:0] r_addr;
  logic [47:0] r_data;
  logic [1:0]  r_err;
  logic [15:0] r_poll_cnt;
  logic [15:0] r_gap_cnt;
  logic        r_started;

  logic        w_accept;
  logic        w_start;
  logic [7:0]  w_cmd;
  logic [23:0] w_addr;
  logic [47:0] w_val;
  logic        w_set_err;
  logic [1:0]  w_err_val;
  logic        w_poll_inc;
  logic [15:0] w_poll_next;
  logic        w_txn_done;
  logic        w_txn_timeout;

  // Only the status bits of the read data matter to this block
  logic        w_unused_memdata;
  assign w_unused_memdata = ^MEMDATA[47:2];

  assign w_poll_next = sat_inc16(r_poll_cnt);

  mem_txn_handshake #(
    .ACK_TIMEOUT (ACK_TIMEOUT)
  ) u_txn (
    .i_clk         (CLK),
    .i_rst         (CMD_RST),
    .i_start       (w_start),
    .i_cmd         (w_cmd),
    .i_addr        (w_addr),
    .i_val         (w_val),
    .i_mem_busy    (MEM_CTRL_busy),
    .o_memcmd      (MEMCMD),
    .o_memaddr     (MEMADDR),
    .o_memval      (MEMVAL),
    .o_memtrig     (MEMTRIG),
    .o_txn_done    (w_txn_done),
    .o_txn_timeout (w_txn_timeout)
  );

  // State register, request latch, result registers and gap counter
  always_ff @(posedge CLK) begin
    if (CMD_RST) begin
      r_state    <= S_IDLE;
      r_op       <= 1'b0;
      r_addr     <= 24'd0;
      r_data     <= 48'd0;
      r_err      <= ERR_OK;
      r_poll_cnt <= 16'd0;
      r_gap_cnt  <= 16'd0;
      r_started  <= 1'b0;
    end else begin
      r_state <= w_next;
      // One transaction per visit to a transaction state
      if (w_next != r_state) begin
        r_started <= 1'b0;
      end else if (w_start) begin
        r_started <= 1'b1;
      end
      if (r_state == S_GAP) begin
        r_gap_cnt <= r_gap_cnt + 16'd1;
      end else begin
        r_gap_cnt <= 16'd0;
      end
      if (w_accept) begin
        r_op       <= req_op;
        r_addr     <= req_addr;
        r_data     <= req_data;
        r_err      <= ERR_OK;
        r_poll_cnt <= 16'd0;
      end
      if (w_set_err) begin
        r_err <= w_err_val;
      end
      if (w_poll_inc) begin
        r_poll_cnt <= w_poll_next;
      end
    end
  end

  // Next state, transaction request and result updates
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_start    = 1'b0;
    w_cmd      = WREN_CMD;
    w_addr     = 24'd0;
    w_val      = 48'd0;
    w_set_err  = 1'b0;
    w_err_val  = ERR_OK;
    w_poll_inc = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          w_next   = S_WREN;
        end
      end
      S_WREN: begin
        w_start = ~r_started;
        w_cmd   = WREN_CMD;
        if (w_txn_done) begin
          w_next = S_WEL_CHK;
        end
      end
      S_WEL_CHK: begin
        w_start = ~r_started;
        w_cmd   = RDSR_CMD;
        if (w_txn_done) begin
          if (MEMDATA[1]) begin
            w_next = S_OP;
          end else begin
            w_set_err = 1'b1;
            w_err_val = ERR_WEL;
            w_next    = S_DONE;
          end
        end
      end
      S_OP: begin
        w_start = ~r_started;
        w_cmd   = r_op ? ERASE_CMD : PROG_CMD;
        w_addr  = r_addr;
        w_val   = r_op ? 48'd0 : r_data;
        if (w_txn_done) begin
          w_next = S_GAP;
        end
      end
      S_GAP: begin
        if (r_gap_cnt == 16'(POLL_GAP - 1)) begin
          w_next = S_POLL;
        end
      end
      S_POLL: begin
        w_start = ~r_started;
        w_cmd   = RDSR_CMD;
        if (w_txn_done) begin
          w_poll_inc = 1'b1;
          if (!MEMDATA[0]) begin
            w_next = S_DONE;
          end else if (w_poll_next == MAX_POLLS) begin
            w_set_err = 1'b1;
            w_err_val = ERR_POLL_TO;
            w_next    = S_DONE;
          end else begin
            w_next = S_GAP;
          end
        end
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    // A controller that never acknowledges ends the sequence from any
    // transaction state
    if (w_txn_timeout) begin
      w_set_err = 1'b1;
      w_err_val = ERR_ACK_TO;
      w_next    = S_DONE;
    end
  end

  assign seq_busy   = (r_state != S_IDLE) && (r_state != S_DONE);
  assign done       = (r_state == S_DONE);
  assign err        = r_err;
  assign poll_count = r_poll_cnt;

endmodule

// File: tb/tb_flash_program_sequencer.sv
// Directed bench for flash_program_sequencer with a behavioural memory
// controller and a sequence-level expected-transaction scoreboard.
module tb_flash_program_sequencer;

  localparam int MAXP   = 8;
  localparam int ACK_TO = 255;
  localparam int TW     = 81;  // {check_payload, cmd, addr, val}

  logic        CLK;
  logic        CMD_RST;
  logic        req;
  logic        req_op;
  logic [23:0] req_addr;
  logic [47:0] req_data;
  logic        seq_busy;
  logic        done;
  logic [1:0]  err;
  logic [15:0] poll_count;
  logic [7:0]  MEMCMD;
  logic [23:0] MEMADDR;
  logic [47:0] MEMVAL;
  logic        MEMTRIG;
  logic        MEM_CTRL_busy;
  logic [47:0] MEMDATA;

  flash_program_sequencer #(
    .MAX_POLLS (16'(MAXP))
  ) dut (
    .CLK           (CLK),
    .CMD_RST       (CMD_RST),
    .req           (req),
    .req_op        (req_op),
    .req_addr      (req_addr),
    .req_data      (req_data),
    .seq_busy      (seq_busy),
    .done          (done),
    .err           (err),
    .poll_count    (poll_count),
    .MEMCMD        (MEMCMD),
    .MEMADDR       (MEMADDR),
    .MEMVAL        (MEMVAL),
    .MEMTRIG       (MEMTRIG),
    .MEM_CTRL_busy (MEM_CTRL_busy),
    .MEMDATA       (MEMDATA)
  );

  // ---------------- clock / reset ----------------
  int cyc;
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end
  initial cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: actual time limit reached, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int checks;
  int errors;
  logic [TW-1:0] exp_q[$];
  logic [1:0]    exp_err;
  logic [15:0]   exp_polls;
  int            done_cnt;
  int            done_cyc;
  int            txn_seen;
  int            wren_seen;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Sequence model: what the requester must see, from the flash protocol rules
  task automatic build_seq(input logic op, input logic [23:0] addr, input logic [47:0] data,
                           input logic [7:0] sr1, input int wip, input bit dead);
    int n;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'h06, 24'd0, 48'd0});
    exp_polls = 16'd0;
    if (dead) begin
      exp_err = 2'b11;
      return;
    end
    exp_q.push_back({1'b0, 8'h05, 24'd0, 48'd0});
    if (!sr1[1]) begin
      exp_err = 2'b01;
      return;
    end
    exp_q.push_back({1'b1, (op ? 8'hD8 : 8'h11), addr, (op ? 48'd0 : data)});
    if (wip >= 0 && wip + 1 <= MAXP) begin
      n = wip + 1;
      exp_err = 2'b00;
    end else begin
      n = MAXP;
      exp_err = 2'b10;
    end
    exp_polls = 16'(n);
    for (int i = 0; i < n; i++) exp_q.push_back({1'b0, 8'h05, 24'd0, 48'd0});
  endtask

  // ---------------- memory controller model ----------------
  bit         ack_dead;
  logic [7:0] wel_sr1;
  int         wip_left;
  int         rdsr_idx;
  localparam logic [47:0] GARBAGE = 48'hFFFF_FFFF_FFFF;

  initial begin
    logic [7:0] st;
    logic [7:0] c;
    MEM_CTRL_busy = 1'b0;
    MEMDATA = GARBAGE;
    rdsr_idx = 0;
    forever begin
      @(negedge CLK);
      if (MEMTRIG && !ack_dead && !CMD_RST) begin
        c = MEMCMD;
        st = 8'h00;
        if (c == 8'h06) rdsr_idx = 0;
        if (c == 8'h05) begin
          if (rdsr_idx == 0) st = wel_sr1;
          else if (wip_left != 0) begin
            st = 8'h01;
            if (wip_left > 0) wip_left--;
          end
          rdsr_idx++;
        end
        @(negedge CLK);
        MEM_CTRL_busy = 1'b1;
        repeat (2) @(negedge CLK);
        MEM_CTRL_busy = 1'b0;
        MEMDATA = {40'hA5A5A5A5A5, st};
        @(negedge CLK);
        MEMDATA = GARBAGE;
      end
    end
  end

  // ---------------- compare process ----------------
  logic          prev_trig;
  bit            in_txn;
  logic [TW-1:0] cur;
  int            trig_len;

  initial begin
    prev_trig = 1'b0;
    in_txn = 1'b0;
    trig_len = 0;
    done_cnt = 0;
    done_cyc = 0;
    txn_seen = 0;
    wren_seen = 0;
  end

  always @(negedge CLK) begin
    if (!CMD_RST) begin
      if (MEMTRIG && !prev_trig) begin
        txn_seen++;
        if (MEMCMD == 8'h06) wren_seen++;
        cur = {1'b0, MEMCMD, MEMADDR, MEMVAL};
        in_txn = 1'b1;
        if (exp_q.size() == 0) begin
          chk("unexpected_txn_cmd", 64'(MEMCMD), 64'hFFFF);
        end else begin
          logic [TW-1:0] e;
          e = exp_q.pop_front();
          chk("txn_cmd", 64'(MEMCMD), 64'(e[79:72]));
          if (e[80]) begin
            chk("txn_addr", 64'(MEMADDR), 64'(e[71:48]));
            chk("txn_val", 64'(MEMVAL), 64'(e[47:0]));
          end
        end
      end else if (in_txn && (MEMTRIG || MEM_CTRL_busy)) begin
        chk("stable_cmd", 64'(MEMCMD), 64'(cur[79:72]));
        chk("stable_addr", 64'(MEMADDR), 64'(cur[71:48]));
        chk("stable_val", 64'(MEMVAL), 64'(cur[47:0]));
      end else if (in_txn) begin
        in_txn = 1'b0;
      end
      if (MEMTRIG) begin
        chk("busy_in_txn", 64'(seq_busy), 64'd1);
        trig_len++;
      end else if (prev_trig) begin
        if (ack_dead) begin
          chk("ack_to_trig_len", 64'(trig_len), 64'(ACK_TO));
          chk("ack_to_done_now", 64'(done), 64'd1);
        end
        trig_len = 0;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_busy_low", 64'(seq_busy), 64'd0);
        chk("done_err", 64'(err), 64'(exp_err));
        chk("done_polls", 64'(poll_count), 64'(exp_polls));
        chk("done_txns_left", 64'(exp_q.size()), 64'd0);
      end
    end
    prev_trig = MEMTRIG;
  end

  // ---------------- driver tasks ----------------
  int t_req;

  task automatic do_req(input logic op, input logic [23:0] addr, input logic [47:0] data);
    @(negedge CLK);
    req = 1'b1;
    req_op = op;
    req_addr = addr;
    req_data = data;
    t_req = cyc;
    @(negedge CLK);
    req = 1'b0;
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int n;
    n = 0;
    while (done_cnt <= start_cnt && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (done_cnt <= start_cnt) chk("done_wait_timeout", 64'(n), 64'(-1));
  endtask

  task automatic wait_txns(input int target, input int budget);
    int n;
    n = 0;
    while (txn_seen < target && n < budget) begin
      @(negedge CLK);
      n++;
    end
    if (txn_seen < target) chk("txn_wait_timeout", 64'(txn_seen), 64'(target));
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int d0;
    int base;
    checks = 0;
    errors = 0;
    exp_err = 2'b00;
    exp_polls = 16'd0;
    ack_dead = 1'b0;
    wel_sr1 = 8'h02;
    wip_left = 0;
    req = 1'b0;
    req_op = 1'b0;
    req_addr = 24'd0;
    req_data = 48'd0;
    CMD_RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("rst_seq_busy", 64'(seq_busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_poll_count", 64'(poll_count), 64'd0);
    chk("rst_memcmd", 64'(MEMCMD), 64'd0);
    chk("rst_memaddr", 64'(MEMADDR), 64'd0);
    chk("rst_memval", 64'(MEMVAL), 64'd0);
    chk("rst_memtrig", 64'(MEMTRIG), 64'd0);
    CMD_RST = 1'b0;
    repeat (2) @(negedge CLK);

    // Program, WIP for 3 polls
    build_seq(1'b0, 24'h012345, 48'hA1B2C3D4E5F6, 8'h02, 3, 1'b0);
    chk("model_prog_len", 64'(exp_q.size()), 64'd7);
    chk("model_prog_op", 64'(exp_q[2][79:72]), 64'h11);
    wel_sr1 = 8'h02; wip_left = 3;
    d0 = done_cnt;
    do_req(1'b0, 24'h012345, 48'hA1B2C3D4E5F6);
    wait_done(d0, 2000);
    chk("prog_err", 64'(err), 64'd0);
    chk("prog_polls", 64'(poll_count), 64'd4);
    repeat (3) @(negedge CLK);
    chk("prog_polls_held", 64'(poll_count), 64'd4);

    // WEL not set
    build_seq(1'b0, 24'h000100, 48'h0000_1111_2222, 8'h00, 0, 1'b0);
    wel_sr1 = 8'h00; wip_left = 0;
    d0 = done_cnt;
    do_req(1'b0, 24'h000100, 48'h0000_1111_2222);
    wait_done(d0, 2000);
    chk("wel_err", 64'(err), 64'd1);
    chk("wel_polls", 64'(poll_count), 64'd0);
    repeat (3) @(negedge CLK);
    chk("wel_err_held", 64'(err), 64'd1);

    // Poll timeout, WIP stuck
    build_seq(1'b0, 24'hABCDEF, 48'h0102_0304_0506, 8'h02, -1, 1'b0);
    chk("model_pto_len", 64'(exp_q.size()), 64'd11);
    wel_sr1 = 8'h02; wip_left = -1;
    d0 = done_cnt;
    do_req(1'b0, 24'hABCDEF, 48'h0102_0304_0506);
    wait_done(d0, 3000);
    chk("pto_err", 64'(err), 64'd2);
    chk("pto_polls", 64'(poll_count), 64'd8);

    // Controller never acknowledges
    build_seq(1'b0, 24'h000000, 48'd0, 8'h02, 0, 1'b1);
    ack_dead = 1'b1; wip_left = 0;
    d0 = done_cnt;
    do_req(1'b0, 24'h000000, 48'd0);
    wait_done(d0, 1000);
    repeat (2) @(negedge CLK);
    ack_dead = 1'b0;
    chk("ackto_err", 64'(err), 64'd3);
    chk("ackto_trig_low", 64'(MEMTRIG), 64'd0);

    // Erase aborted by reset in the poll gap
    build_seq(1'b1, 24'h010000, 48'h1234_5678_9ABC, 8'h02, 2, 1'b0);
    wel_sr1 = 8'h02; wip_left = 2;
    base = txn_seen;
    d0 = done_cnt;
    do_req(1'b1, 24'h010000, 48'h1234_5678_9ABC);
    wait_txns(base + 3, 500);
    repeat (10) @(negedge CLK);
    CMD_RST = 1'b1;
    @(negedge CLK);
    chk("abort_trig", 64'(MEMTRIG), 64'd0);
    chk("abort_busy", 64'(seq_busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    CMD_RST = 1'b0;
    exp_q.delete();
    repeat (30) @(negedge CLK);
    chk("abort_no_done", 64'(done_cnt), 64'(d0));

    // Fresh erase, ready on first poll: 4 txns of 5 cycles + gap + 2
    build_seq(1'b1, 24'h010000, 48'h1234_5678_9ABC, 8'h02, 0, 1'b0);
    wel_sr1 = 8'h02; wip_left = 0;
    d0 = done_cnt;
    do_req(1'b1, 24'h010000, 48'h1234_5678_9ABC);
    wait_done(d0, 2000);
    chk("erase_latency", 64'(done_cyc - t_req + 1), 64'd38);
    chk("erase_err", 64'(err), 64'd0);
    chk("erase_polls", 64'(poll_count), 64'd1);

    // Second request while busy is ignored
    build_seq(1'b0, 24'h00FFF0, 48'h0BAD_CAFE_0001, 8'h02, 1, 1'b0);
    wel_sr1 = 8'h02; wip_left = 1;
    base = txn_seen;
    d0 = done_cnt;
    wren_seen = 0;
    do_req(1'b0, 24'h00FFF0, 48'h0BAD_CAFE_0001);
    wait_txns(base + 3, 500);
    @(negedge CLK);
    req = 1'b1;
    req_op = 1'b1;
    req_addr = 24'h777777;
    @(negedge CLK);
    req = 1'b0;
    wait_done(d0, 2000);
    repeat (60) @(negedge CLK);
    chk("busy_req_dones", 64'(done_cnt), 64'(d0 + 1));
    chk("busy_req_wrens", 64'(wren_seen), 64'd1);
    chk("busy_req_polls", 64'(poll_count), 64'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
